// File: rtl/fft_frame_pkg.sv
// rtl/fft_frame_pkg.sv - shared constants and types for the FFT frame scheduler
package fft_frame_pkg;

  localparam int N_LOG2_DEF    = 10;
  localparam int FRAME_DEF     = 1 << N_LOG2_DEF;
  localparam int DEPTH_DEF     = 2 * FRAME_DEF;
  localparam int PTR_W_DEF     = N_LOG2_DEF + 2;
  localparam int HOP_DEF       = 512;
  localparam int META_WDTH_DEF = 11;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  // Ring pointers carry one wrap bit above the 2*FRAME RAM address
  function automatic int ptr_width(input int n_log2);
    return n_log2 + 2;
  endfunction

endpackage

// File: rtl/frame_ring_ram.sv
// rtl/frame_ring_ram.sv - simple dual-port sample RAM with one-cycle registered read
module frame_ring_ram #(
  parameter int AW = 11,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // Write port: storage itself is never reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: registered so the frame sample lines up with its tag one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_frame_sched.sv
// rtl/fft_frame_sched.sv - cuts a sample stream into overlapping frames for the window/FFT
module fft_frame_sched
  import fft_frame_pkg::*;
#(
  parameter int N_LOG2       = N_LOG2_DEF,
  parameter int HOP          = HOP_DEF,
  parameter int DIN_WDTH     = 32,
  parameter int META_WDTH    = META_WDTH_DEF,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 flush,
  input  logic [DIN_WDTH-1:0]  s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [DIN_WDTH-1:0]  fft_din,
  output logic                 fft_nd,
  output logic [N_LOG2-1:0]    win_idx,
  output logic [META_WDTH-1:0] fft_meta,
  input  logic                 fft_dout_nd,
  output logic                 frame_done,
  output logic [META_WDTH-1:0] done_idx,
  output logic                 busy
);

  localparam int PW = ptr_width(N_LOG2);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [PW-1:0] FRAME_P = PW'(1 << N_LOG2);
  localparam logic [PW-1:0] DEPTH_P = PW'(2 << N_LOG2);
  localparam logic [PW-1:0] HOP_P   = PW'(HOP);
  localparam logic [IW-1:0] MAX_P   = IW'(MAX_INFLIGHT);

  state_e                state_q, state_d;
  logic [PW-1:0]         wr_ptr_q, next_start_q;
  logic [N_LOG2-1:0]     k_q, k_d, out_cnt_q, win_idx_q;
  logic [META_WDTH-1:0]  frame_cnt_q, done_cnt_q, fft_meta_q, done_idx_q;
  logic [IW-1:0]         inflight_q;
  logic                  flush_pend_q, fft_nd_q, frame_done_q;

  logic [PW-1:0]         occ, occ_hop, hop_start;
  logic [PW-2:0]         rd_addr;
  logic                  wr_en, credit_ok, start_ok, cont_ok, flush_now;
  logic                  frame_end, rd_en, issue, wrap, dec;

  assign hop_start = next_start_q + HOP_P;
  assign occ       = wr_ptr_q - next_start_q;
  assign occ_hop   = wr_ptr_q - hop_start;
  assign s_ready   = (occ < DEPTH_P);
  assign wr_en     = s_valid && s_ready;
  assign credit_ok = (inflight_q < MAX_P);
  assign flush_now = flush_pend_q || flush;
  assign start_ok  = en && !flush && (occ >= FRAME_P) && credit_ok;
  assign cont_ok   = en && !flush_now && (occ_hop >= FRAME_P) && credit_ok;
  assign frame_end = (state_q == STREAM) && (k_q == '1);
  assign rd_addr   = next_start_q[PW-2:0] + {1'b0, k_q};
  assign k_d       = rd_en ? k_q + N_LOG2'(1) : '0;
  assign wrap      = fft_dout_nd && (out_cnt_q == '1);
  assign dec       = wrap && (inflight_q != '0);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: a frame either chains into the next one or drops back to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = STREAM;
      STREAM:  if (frame_end && !cont_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: ring read strobe and frame-issue strobe for the credit counter
  always_comb begin
    rd_en = 1'b0;
    issue = 1'b0;
    case (state_q)
      IDLE: begin
        rd_en = start_ok;
        issue = start_ok;
      end
      STREAM: begin
        rd_en = 1'b1;
        issue = frame_end && cont_ok;
      end
      default: ;
    endcase
  end

  // Write pointer advances once per accepted sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     wr_ptr_q <= '0;
    else if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
  end

  // Frame position, hop advance and deferred flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q          <= '0;
      next_start_q <= '0;
      frame_cnt_q  <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      k_q <= k_d;
      if ((state_q == IDLE) && flush) next_start_q <= wr_ptr_q;
      else if (frame_end)             next_start_q <= flush_now ? wr_ptr_q : hop_start;
      if (frame_end) frame_cnt_q <= frame_cnt_q + META_WDTH'(1);
      if (frame_end)                            flush_pend_q <= 1'b0;
      else if ((state_q == STREAM) && flush)    flush_pend_q <= 1'b1;
    end
  end

  // Output tags follow the registered RAM read by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fft_nd_q   <= 1'b0;
      win_idx_q  <= '0;
      fft_meta_q <= '0;
    end else begin
      fft_nd_q <= rd_en;
      if (rd_en) begin
        win_idx_q  <= k_q;
        fft_meta_q <= frame_cnt_q;
      end
    end
  end

  // FFT output counting, completion pulse and frames-in-flight credit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt_q    <= '0;
      done_cnt_q   <= '0;
      done_idx_q   <= '0;
      frame_done_q <= 1'b0;
      inflight_q   <= '0;
    end else begin
      if (fft_dout_nd) out_cnt_q <= out_cnt_q + N_LOG2'(1);
      frame_done_q <= wrap;
      if (wrap) begin
        done_idx_q <= done_cnt_q;
        done_cnt_q <= done_cnt_q + META_WDTH'(1);
      end
      if (issue && !dec)      inflight_q <= inflight_q + IW'(1);
      else if (!issue && dec) inflight_q <= inflight_q - IW'(1);
    end
  end

  frame_ring_ram #(
    .AW(N_LOG2 + 1),
    .DW(DIN_WDTH)
  ) u_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (wr_en),
    .waddr(wr_ptr_q[PW-2:0]),
    .wdata(s_data),
    .re   (rd_en),
    .raddr(rd_addr),
    .rdata(fft_din)
  );

  assign fft_nd     = fft_nd_q;
  assign win_idx    = win_idx_q;
  assign fft_meta   = fft_meta_q;
  assign frame_done = frame_done_q;
  assign done_idx   = done_idx_q;
  assign busy       = (state_q == STREAM) || (inflight_q != '0);

endmodule

// File: tb/tb_fft_frame_sched.sv
// tb/tb_fft_frame_sched.sv - self-checking bench for fft_frame_sched
module tb_fft_frame_sched;

  localparam int N_LOG2 = 10;
  localparam int FRAME  = 1 << N_LOG2;
  localparam int DW     = 32;
  localparam int MW     = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] fft_din;
  logic          fft_nd;
  logic [N_LOG2-1:0] win_idx;
  logic [MW-1:0] fft_meta;
  logic          fft_dout_nd = 1'b0;
  logic          frame_done;
  logic [MW-1:0] done_idx;
  logic          busy;

  fft_frame_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .flush      (flush),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .fft_din    (fft_din),
    .fft_nd     (fft_nd),
    .win_idx    (win_idx),
    .fft_meta   (fft_meta),
    .fft_dout_nd(fft_dout_nd),
    .frame_done (frame_done),
    .done_idx   (done_idx),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0]     d;
    logic [N_LOG2-1:0] idx;
    logic [MW-1:0]     meta;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] first_seen[$];
  int errors = 0, checks = 0, cyc = 0;
  int fed = 0, feed_limit = 0, acc_total = 0, pulses = 0, done_seen = 0;
  int arm_hs = 0, first_due = -1;
  logic [DW-1:0] data_base = '0;
  logic feeding = 1'b0, arm_first = 1'b0, done_due = 1'b0, prev_nd = 1'b0;
  logic [N_LOG2-1:0] prev_idx = '0, obs_idx = '0;
  logic [MW-1:0] exp_done = '0, obs_meta = '0;
  logic obs_nd = 1'b0, found;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // A frame of the model: FRAME consecutive stream samples starting at 'start'
  task automatic push_frame(input logic [DW-1:0] start, input int meta);
    for (int i = 0; i < FRAME; i++)
      exp_q.push_back(beat_t'{d: start + DW'(i), idx: N_LOG2'(i), meta: MW'(meta)});
  endtask

  task automatic arm(input logic [DW-1:0] base, input int limit);
    data_base = base; fed = 0; feed_limit = limit; feeding = 1'b1;
    arm_first = 1'b1; arm_hs = 0; first_due = -1;
    s_data = base; s_valid = 1'b1;
  endtask

  // Compare process: runs once per cycle on the falling edge
  task automatic check_cycle();
    beat_t b;
    if (arm_first) begin
      chk("first_beat_timing", 64'(fft_nd), 64'(cyc == first_due));
      if (cyc == first_due) arm_first = 1'b0;
    end
    if (fft_nd) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_beat: got beat idx=%0d meta=%0d required none (cycle %0d)", win_idx, fft_meta, cyc);
      end else begin
        b = exp_q.pop_front();
        chk("beat_din", 64'(fft_din), 64'(b.d));
        chk("beat_idx", 64'(win_idx), 64'(b.idx));
        chk("beat_meta", 64'(fft_meta), 64'(b.meta));
        if (win_idx == '0) first_seen.push_back(fft_din);
      end
    end
    if (prev_nd && prev_idx != '1) chk("frame_gap", 64'(fft_nd), 64'd1);
    prev_nd = fft_nd; prev_idx = win_idx;
    obs_nd = fft_nd; obs_idx = win_idx; obs_meta = fft_meta;
    chk("frame_done", 64'(frame_done), 64'(done_due));
    if (frame_done && done_due) begin
      chk("done_idx", 64'(done_idx), 64'(exp_done));
      exp_done = exp_done + MW'(1);
      done_seen++;
    end
    done_due = 1'b0;
    if (fft_dout_nd) begin
      pulses++;
      if (pulses % FRAME == 0) done_due = 1'b1;
    end
    if (s_valid && s_ready) begin
      fed++; acc_total++;
      if (arm_first) begin
        arm_hs++;
        if (arm_hs == FRAME) first_due = cyc + 2;
      end
    end
    cyc++;
  endtask

  task automatic drive();
    s_valid = feeding && (fed < feed_limit);
    s_data  = data_base + DW'(fed);
  endtask

  task automatic tick();
    @(negedge clk); check_cycle();
    @(posedge clk); #1; drive();
  endtask

  initial begin
    // Reset holds everything idle even with a valid sample offered
    s_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_fft_nd", 64'(fft_nd), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fft_din", 64'(fft_din), 64'd0);
    chk("rst_win_idx", 64'(win_idx), 64'd0);
    chk("rst_fft_meta", 64'(fft_meta), 64'd0);
    chk("rst_done_idx", 64'(done_idx), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1; en = 1'b1;
    arm('0, 1 << 30);

    // First frame, overlap and credit stall with no FFT output
    push_frame(DW'(0), 0);
    push_frame(DW'(512), 1);
    push_frame(DW'(1024), 2);
    for (int i = 0; i < 6000 && exp_q.size() > FRAME; i++) tick();
    repeat (600) tick();
    chk("stall_accepted", 64'(acc_total), 64'd3072);
    chk("stall_s_ready", 64'(s_ready), 64'd0);
    chk("stall_frame2_held", 64'(exp_q.size()), 64'(FRAME));
    chk("stall_busy", 64'(busy), 64'd1);
    fft_dout_nd = 1'b1;
    repeat (FRAME) tick();
    fft_dout_nd = 1'b0;
    for (int i = 0; i < 1300 && exp_q.size() > 0; i++) tick();
    chk("frame2_drained", 64'(exp_q.size()), 64'd0);
    chk("done_count_a", 64'(done_seen), 64'd1);
    for (int i = 0; i < 20 && !s_ready; i++) tick();
    chk("s_ready_reassert", 64'(s_ready), 64'd1);
    chk("frames_seen_a", 64'(first_seen.size()), 64'd3);
    if (first_seen.size() >= 3) begin
      chk("f0_first_din", 64'(first_seen[0]), 64'd0);
      chk("f1_first_din", 64'(first_seen[1]), 64'd512);
      chk("f2_first_din", 64'(first_seen[2]), 64'd1024);
    end

    // en dropped mid-frame: the frame completes, nothing follows
    feeding = 1'b0; s_valid = 1'b0;
    push_frame(DW'(1536), 3);
    fft_dout_nd = 1'b1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      if (obs_nd && obs_idx == 10'd100 && obs_meta == 11'd3) en = 1'b0;
    end
    fft_dout_nd = 1'b0;
    repeat (1200) tick();
    chk("en_low_frame_complete", 64'(exp_q.size()), 64'd0);
    chk("done_count_b", 64'(done_seen), 64'd4);
    chk("idle_busy", 64'(busy), 64'd0);

    // Flush discards buffered history; next frame starts at the first new sample
    flush = 1'b1;
    tick();
    flush = 1'b0; en = 1'b1;
    repeat (50) tick();
    push_frame(DW'('h1000), 4);
    arm(DW'('h1000), FRAME);
    found = 1'b0;
    for (int i = 0; i < 2500 && !found; i++) begin
      @(negedge clk); check_cycle();
      if (fft_nd && win_idx == 10'd300) found = 1'b1;
      else begin @(posedge clk); #1; drive(); end
    end
    chk("reach_idx300", 64'(found), 64'd1);

    // Asynchronous reset in the middle of a frame
    #2 rst_n = 1'b0;
    #1;
    chk("async_fft_nd", 64'(fft_nd), 64'd0);
    chk("async_busy", 64'(busy), 64'd0);
    chk("async_fft_meta", 64'(fft_meta), 64'd0);
    exp_q.delete();
    prev_nd = 1'b0; done_due = 1'b0; pulses = 0; exp_done = '0; done_seen = 0;
    arm_first = 1'b0; feeding = 1'b0; s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    push_frame(DW'('h2000), 0);
    arm(DW'('h2000), FRAME);
    for (int i = 0; i < 2500 && exp_q.size() > 0; i++) tick();
    chk("restart_drained", 64'(exp_q.size()), 64'd0);
    fft_dout_nd = 1'b1;
    repeat (FRAME) tick();
    fft_dout_nd = 1'b0;
    repeat (5) tick();
    chk("done_after_reset", 64'(done_seen), 64'd1);
    chk("final_busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_frame_sched.md
Name: fft_frame_sched

Overview:
- Frame scheduler in front of the Hamming window and R22SDF FFT of the log-mel front end.
- Buffers a continuous audio sample stream in an internal ring RAM and cuts it into overlapping frames of 2^N_LOG2 samples with hop HOP.
- Streams each frame to the window/FFT with a sample index and a frame-number meta tag.
- Limits frames in flight inside the FFT pipeline by counting FFT output strobes.

Parameters:
- N_LOG2, 10: log2 frame length (FRAME = 1024).
- HOP, 512: hop between frame starts, 1..FRAME.
- DIN_WDTH, 32: sample width.
- META_WDTH, 11: frame-tag width, matches FFT meta path.
- MAX_INFLIGHT, 2: maximum frames issued but not yet fully output by the FFT.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  allow new frames to start
- flush  in  1  pulse: discard buffered history
- s_data  in  DIN_WDTH  input sample
- s_valid  in  1  sample valid
- s_ready  out  1  sample accepted when s_valid & s_ready
- fft_din  out  DIN_WDTH  frame sample to window/FFT
- fft_nd  out  1  fft_din valid
- win_idx  out  N_LOG2  index of sample within frame (window ROM address)
- fft_meta  out  META_WDTH  frame number, constant over a frame
- fft_dout_nd  in  1  FFT output-valid strobe
- frame_done  out  1  one-cycle pulse when the FFT has output FRAME samples
- done_idx  out  META_WDTH  number of the completed frame, valid with frame_done
- busy  out  1  state STREAM or inflight != 0

Behaviour:
- Reset (async, rst_n low):
  - fft_nd, frame_done, busy = 0; fft_din, win_idx, fft_meta, done_idx = 0; s_ready = 1.
  - wr_ptr, next_start, frame_cnt, done_cnt, inflight, out_cnt = 0; state IDLE.
  - Buffered samples are lost.
  - Mid-frame reset drops fft_nd immediately; the frame is not resumed.
- Ring RAM:
  - Depth 2*FRAME, simple dual-port, registered read.
  - Pointers are N_LOG2+2 bits (one wrap bit).
- Write side:
  - occ = wr_ptr - next_start.
  - s_ready = (occ < 2*FRAME).
  - Each handshake writes RAM[wr_ptr] and increments wr_ptr.
- Start condition: state IDLE, en=1, occ >= FRAME, inflight < MAX_INFLIGHT.
- FSM IDLE:
  - On the start condition, go to STREAM with k=0.
  - Issue the read of next_start+0 in that same cycle.
  - inflight increments.
- FSM STREAM:
  - Read address next_start+k, k increments every cycle; no gaps inside a frame.
  - At k = FRAME-1: next_start += HOP; frame_cnt increments (wraps at 2^META_WDTH).
  - If the start condition (evaluated with the updated next_start) holds, continue to the next frame with no bubble.
  - Otherwise go to IDLE.
- Output timing:
  - One cycle after each read, the block drives fft_nd=1, fft_din = RAM data, win_idx = k, fft_meta = frame_cnt.
  - fft_nd is therefore asserted 2 cycles after the handshake that completes occ >= FRAME.
- Completion:
  - out_cnt counts fft_dout_nd modulo FRAME.
  - At wrap: frame_done=1, done_idx = done_cnt, then done_cnt increments and inflight decrements.
  - Simultaneous increment and decrement leave inflight unchanged.
  - inflight never exceeds MAX_INFLIGHT.
- en low during STREAM: the current frame finishes fully; no new frame starts.
- flush:
  - In IDLE, next_start := wr_ptr in the next cycle.
  - In STREAM, the flush is latched and applied at frame end, which suppresses back-to-back continuation.
  - frame_cnt, done_cnt and inflight are unaffected.
- Simultaneous write and read of the same address cannot occur: occ >= FRAME is required before streaming, and s_ready protects unread data.

Decomposition:
- Package fft_frame_pkg: FRAME, DEPTH, pointer width, state enum {IDLE, STREAM}, default HOP/META_WDTH.
- Sub-module frame_ring_ram: parameterised simple dual-port RAM, 1-cycle registered read.
- All other logic (pointers, FSM, credit counter, output counter) lives in fft_frame_sched.

Test Plan:
- Reset check: assert rst_n=0 with s_valid=1 -> all outputs 0, s_ready=1; after release, nothing issues until 1024 samples are accepted.
- First frame: feed samples 0..1023 at 1/cycle, fft_dout_nd=0 -> 1023 samples produce no fft_nd; fft_nd rises 2 cycles after sample 1023's handshake; 1024 contiguous beats with fft_din=0..1023, win_idx=0..1023, fft_meta=0.
- Overlap: keep feeding samples 1024..2047 -> second frame fft_din=512..1535, fft_meta=1; third frame starts at 1024, fft_meta=2.
- Credit stall: MAX_INFLIGHT=2, fft_dout_nd held low, feed continuously:
  - frames 0 and 1 issue; frame 2 does not; s_ready drops at occ=2048.
  - Then pulse fft_dout_nd 1024 times -> frame_done once with done_idx=0; frame 2 starts with fft_meta=2; s_ready reasserts.
- en/flush: deassert en at win_idx=100 -> all 1024 beats still issue, then fft_nd stays 0 with data buffered. Pulse flush, then re-enable en -> no frame until 1024 new samples arrive; the next frame's first fft_din is the first post-flush sample.
- Async reset mid-frame at win_idx=300 -> fft_nd=0 and inflight=0 without a clock edge; the restart behaves like the first-frame scenario with fft_meta=0.
